uart_rx_frame_ctrl: RTL
=======================

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 Parameter SYNC_BYTE, 8'hA5, frame start marker.
REQ-002 Parameter MAX_LEN, 8, maximum payload bytes per frame (power of 2, 2..16).
REQ-003 Parameter TIMEOUT_CYCLES, 50000, clk cycles allowed between bytes inside a frame.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 byte_valid  input  1  one-cycle strobe from the async receiver: byte_in is valid.
REQ-007 byte_in  input  8  received byte, sampled only when byte_valid=1.
REQ-008 pl_valid  output  1  payload byte available on pl_data.
REQ-009 pl_data  output  8  current payload byte.
REQ-010 pl_last  output  1  high with pl_valid on the final payload byte of the frame.
REQ-011 pl_ready  input  1  consumer accepts pl_data; a transfer occurs when pl_valid and pl_ready are both 1.
REQ-012 err_pulse  output  1  one-cycle strobe on a frame error.
REQ-013 err_code  output  2  last error: 00 none, 01 bad length, 10 bad checksum, 11 timeout.
REQ-014 overrun  output  1  one-cycle strobe when a byte is dropped during DRAIN.
REQ-015 frame_cnt  output  8  count of good frames; wraps from 255 to 0.

Function
REQ-016 Frame format SHALL be: SYNC_BYTE, LEN, LEN payload bytes, CHK, where CHK = LEN XOR all payload bytes.
REQ-017 The FSM SHALL have states IDLE, LEN, PAYLOAD, CHK, and DRAIN.
REQ-018 IDLE: byte_valid with byte_in==SYNC_BYTE -> LEN; any other byte is ignored with no error.
REQ-019 LEN: byte_valid with 1<=byte_in<=MAX_LEN stores the length, seeds the checksum with byte_in, clears the write pointer, and goes to PAYLOAD.
REQ-020 LEN: byte_valid with byte_in==0 or byte_in>MAX_LEN -> IDLE, err_pulse, err_code=01.
REQ-021 PAYLOAD: each byte_valid writes byte_in to buf[wr_ptr], XORs it into the checksum, and increments wr_ptr; after the LEN-th byte -> CHK.
REQ-022 CHK: byte_valid with byte_in==checksum -> DRAIN, frame_cnt+1.
REQ-023 CHK: byte_valid with byte_in!=checksum -> IDLE, err_pulse, err_code=10; the buffer content is discarded.
REQ-024 Timeout: the gap counter clears on every byte_valid and on entry to LEN.
REQ-025 In LEN/PAYLOAD/CHK, the gap counter reaching TIMEOUT_CYCLES-1 with no byte_valid SHALL force IDLE, err_pulse, err_code=11.
REQ-026 If byte_valid and the timeout coincide, the byte SHALL win and no timeout is flagged.
REQ-027 The gap counter SHALL hold at zero in IDLE and DRAIN.
REQ-028 DRAIN: pl_valid=1 and pl_data=buf[rd_ptr], with rd_ptr starting at 0; pl_last=(rd_ptr==LEN-1).
REQ-029 DRAIN: each transfer increments rd_ptr; the transfer with pl_last -> IDLE on the next edge, with pl_valid=0 from that cycle.
REQ-030 pl_valid SHALL first assert the cycle after the CHK byte strobe (latency 1 clk); pl_data SHALL be stable while pl_valid=1 and pl_ready=0.
REQ-031 DRAIN: byte_valid SHALL drop the byte and pulse overrun; this includes a SYNC_BYTE, so no new frame starts until IDLE.
REQ-032 err_code SHALL hold its value until the next error; err_pulse and overrun SHALL be registered, never combinational.
REQ-033 Outside DRAIN, pl_valid, pl_last SHALL be 0; pl_data is don't-care but SHALL not be X after reset.

Reset
REQ-034 rst SHALL force IDLE, pointers=0, checksum=0, gap counter=0, pl_valid=0, pl_last=0, pl_data=0, err_pulse=0, err_code=00, overrun=0, frame_cnt=0.
REQ-035 rst mid-frame or mid-DRAIN SHALL abandon the frame with no err_pulse; the buffer need not be cleared.

Verification
REQ-036 A5,03,11,22,33,03 (CHK=03^11^22^33=03), pl_ready=1 -> pl_data 11,22,33 on consecutive cycles; pl_last on 33; frame_cnt=1; no err_pulse.
REQ-037 Same frame with pl_ready toggling 0/1 each cycle -> each byte held while stalled, 3 transfers total, IDLE after the last.
REQ-038 A5,09 (MAX_LEN=8) -> err_pulse 1 cycle, err_code=01, IDLE; then A5,01,7F,7E -> one good frame, 7F delivered.
REQ-039 A5,02,10,20,00 -> err_code=10, pl_valid never asserted, frame_cnt unchanged.
REQ-040 A5,02,10 then no byte for TIMEOUT_CYCLES (set to 16) -> err_code=11 exactly at cycle 15 after the 10 strobe; a byte arriving on cycle 15 instead -> no error.
REQ-041 During DRAIN with pl_ready=0, inject A5 -> overrun pulse, drained data unchanged; after drain the FSM is in IDLE; assert rst mid-PAYLOAD -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// Byte-stream frame parser: SYNC, LEN, payload, XOR checksum. It buffers the payload
// and replays it over a valid/ready interface once the checksum matches.
module uart_rx_frame_ctrl #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         MAX_LEN        = 8,
   parameter int         TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_valid,
   input  logic [7:0] byte_in,
   output logic       pl_valid,
   output logic [7:0] pl_data,
   output logic       pl_last,
   input  logic       pl_ready,
   output logic       err_pulse,
   output logic [1:0] err_code,
   output logic       overrun,
   output logic [7:0] frame_cnt
);

   localparam int PTR_W = $clog2(MAX_LEN);
   localparam int LEN_W = PTR_W + 1;
   localparam int GAP_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_PAYLOAD,
      ST_CHK,
      ST_DRAIN
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_LEN     = 2'b01,
      ERR_CHK     = 2'b10,
      ERR_TIMEOUT = 2'b11
   } err_t;

   state_t           state, state_next;
   err_t             err_next;
   logic             err_set, ovr_set, frame_ok;
   logic [LEN_W-1:0] len, wr_ptr, rd_ptr;
   logic [7:0]       chk;
   logic [GAP_W-1:0] gap_cnt;
   logic [7:0]       pl_buf [MAX_LEN];

   logic len_ok, last_wr, in_frame, timeout, pl_wr, len_wr, xfer;

   assign len_ok   = (byte_in != 8'd0) && (byte_in <= MAX_LEN_B);
   assign last_wr  = (wr_ptr == len - LEN_W'(1));
   assign in_frame = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHK);
   // A byte arriving on the expiry cycle wins over the timeout.
   assign timeout  = in_frame && (gap_cnt == GAP_MAX) && !byte_valid;
   assign pl_wr    = (state == ST_PAYLOAD) && byte_valid;
   assign len_wr   = (state == ST_LEN) && byte_valid && len_ok;
   assign xfer     = pl_valid && pl_ready;

   assign pl_valid = (state == ST_DRAIN);
   assign pl_last  = (state == ST_DRAIN) && (rd_ptr == len - LEN_W'(1));
   assign pl_data  = (state == ST_DRAIN) ? pl_buf[rd_ptr[PTR_W-1:0]] : 8'd0;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      err_set    = 1'b0;
      err_next   = ERR_NONE;
      ovr_set    = 1'b0;
      frame_ok   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (byte_valid && (byte_in == SYNC_BYTE)) state_next = ST_LEN;
         end
         ST_LEN: begin
            if (byte_valid) begin
               if (len_ok) begin
                  state_next = ST_PAYLOAD;
               end else begin
                  state_next = ST_IDLE;
                  err_set    = 1'b1;
                  err_next   = ERR_LEN;
               end
            end
         end
         ST_PAYLOAD: begin
            if (byte_valid && last_wr) state_next = ST_CHK;
         end
         ST_CHK: begin
            if (byte_valid) begin
               if (byte_in == chk) begin
                  state_next = ST_DRAIN;
                  frame_ok   = 1'b1;
               end else begin
                  state_next = ST_IDLE;
                  err_set    = 1'b1;
                  err_next   = ERR_CHK;
               end
            end
         end
         ST_DRAIN: begin
            ovr_set = byte_valid;
            if (xfer && pl_last) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      if (timeout) begin
         state_next = ST_IDLE;
         err_set    = 1'b1;
         err_next   = ERR_TIMEOUT;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         len       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         chk       <= '0;
         gap_cnt   <= '0;
         err_pulse <= 1'b0;
         err_code  <= ERR_NONE;
         overrun   <= 1'b0;
         frame_cnt <= '0;
      end else begin
         err_pulse <= err_set;
         overrun   <= ovr_set;
         if (err_set)  err_code  <= err_next;
         if (frame_ok) frame_cnt <= frame_cnt + 8'd1;

         // Counts only while parked in a frame state with no byte; anything else restarts it.
         if (in_frame && !byte_valid && (state_next == state)) gap_cnt <= gap_cnt + GAP_W'(1);
         else                                                  gap_cnt <= '0;

         if (len_wr) begin
            len    <= byte_in[LEN_W-1:0];
            chk    <= byte_in;
            wr_ptr <= '0;
         end else if (pl_wr) begin
            chk    <= chk ^ byte_in;
            wr_ptr <= wr_ptr + LEN_W'(1);
         end

         if (frame_ok)  rd_ptr <= '0;
         else if (xfer) rd_ptr <= rd_ptr + LEN_W'(1);
      end
   end

   // NOTE: the payload buffer has no reset; every entry read in DRAIN was written earlier in the frame.
   always_ff @(posedge clk) begin
      if (pl_wr) pl_buf[wr_ptr[PTR_W-1:0]] <= byte_in;
   end

endmodule
